// File: rtl/uart_pkg.sv
// uart_pkg: shared types and default constants for the UART message blocks
package uart_pkg;
  typedef logic [7:0] uart_byte_t;
  typedef enum logic [1:0] {IDLE, COLLECT, HOLD, DISCARD} rx_msg_state_t;
  localparam uart_byte_t TERM_CHAR_DEF = 8'h0A;
  localparam uart_byte_t MATCH_CHAR_DEF = 8'h45;
endpackage

// File: rtl/msg_buffer.sv
// msg_buffer: MAX_LEN x 8 register file, synchronous write, asynchronous read
module msg_buffer
  import uart_pkg::*;
#(
  parameter int MAX_LEN = 8
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(MAX_LEN)-1:0] waddr,
  input  logic [7:0]                 wdata,
  input  logic [$clog2(MAX_LEN)-1:0] raddr,
  output logic [7:0]                 rdata
);
  uart_byte_t mem [MAX_LEN];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/receive_message.sv
// receive_message: assembles terminated UART messages, holds them until acknowledged
module receive_message
  import uart_pkg::*;
#(
  parameter int         MAX_LEN       = 8,
  parameter uart_byte_t TERM_CHAR     = TERM_CHAR_DEF,
  parameter uart_byte_t MATCH_CHAR    = MATCH_CHAR_DEF,
  parameter int         MESSAGE_COUNT = 3
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_valid,
  input  logic                       rx_err,
  input  logic                       msg_ack,
  input  logic [$clog2(MAX_LEN)-1:0] rd_addr,
  output logic [7:0]                 rd_data,
  output logic                       msg_valid,
  output logic [$clog2(MAX_LEN):0]   msg_len,
  output logic                       msg_match,
  output logic                       overflow,
  output logic [7:0]                 err_count
);
  localparam int AW = $clog2(MAX_LEN);
  rx_msg_state_t state, next;
  logic [AW:0]   ptr;
  logic          all_match, we, byte_in, term_in, err_in, full, ovf_set;
  logic [AW-1:0] waddr;
  assign err_in  = rx_valid && rx_err;
  assign byte_in = rx_valid && !rx_err && rx_data != TERM_CHAR;
  assign term_in = rx_valid && !rx_err && rx_data == TERM_CHAR;
  assign full    = ptr == (AW+1)'(MAX_LEN);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    unique case (state)
      IDLE:    next = byte_in ? COLLECT : term_in ? HOLD : IDLE;
      COLLECT: next = err_in || (byte_in && full) ? DISCARD : term_in ? HOLD : COLLECT;
      HOLD:    next = msg_ack ? IDLE : HOLD;
      DISCARD: next = term_in ? IDLE : DISCARD;
    endcase
  end
  always_comb begin
    we      = byte_in && (state == IDLE || (state == COLLECT && !full));
    waddr   = state == IDLE ? '0 : ptr[AW-1:0];
    ovf_set = byte_in && (state == HOLD || (state == COLLECT && full));
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      msg_valid <= 1'b0;
      msg_len   <= '0;
      msg_match <= 1'b0;
      overflow  <= 1'b0;
      err_count <= '0;
      ptr       <= '0;
      all_match <= 1'b0;
    end else begin
      msg_valid <= next == HOLD;
      if (we) ptr <= state == IDLE ? (AW+1)'(1) : ptr + 1'b1;
      else if (next != state && next != HOLD) ptr <= '0;
      if (we) all_match <= (state == IDLE || all_match) && rx_data == MATCH_CHAR;
      // ptr is 0 in IDLE, so an empty message naturally yields len 0 and no match
      if (state != HOLD && next == HOLD) begin
        msg_len   <= ptr;
        msg_match <= all_match && ptr == (AW+1)'(MESSAGE_COUNT);
      end else if (state == HOLD && msg_ack) msg_match <= 1'b0;
      overflow <= state == IDLE && byte_in ? 1'b0 : ovf_set ? 1'b1 : overflow;
      if (err_in && err_count != 8'hFF) err_count <= err_count + 1'b1;
    end
  msg_buffer #(.MAX_LEN(MAX_LEN)) u_buf (
    .clk  (clk),
    .we   (we),
    .waddr(waddr),
    .wdata(rx_data),
    .raddr(rd_addr),
    .rdata(rd_data)
  );
endmodule

// File: tb/tb_receive_message.sv
// tb_receive_message: directed plus randomized checks against a queue-based message model
module tb_receive_message;
  import uart_pkg::*;
  localparam int MAX_LEN = 8;
  localparam int MC = 3;
  localparam logic [7:0] T = 8'h0A;
  localparam logic [7:0] E = 8'h45;
  logic       clk = 0, rstn = 0, rx_valid = 0, rx_err = 0, msg_ack = 0;
  logic [7:0] rx_data = 0;
  logic [2:0] rd_addr = 0;
  logic [7:0] rd_data, err_count;
  logic       msg_valid, msg_match, overflow;
  logic [3:0] msg_len;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  receive_message #(.MAX_LEN(MAX_LEN), .MESSAGE_COUNT(MC)) dut (
    .clk(clk), .rstn(rstn), .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err),
    .msg_ack(msg_ack), .rd_addr(rd_addr), .rd_data(rd_data), .msg_valid(msg_valid),
    .msg_len(msg_len), .msg_match(msg_match), .overflow(overflow), .err_count(err_count)
  );
  logic [7:0] q[$];
  logic [7:0] m_mem [MAX_LEN];
  bit m_held, m_drop, m_match, m_ovf;
  int m_len, m_err;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // message semantics: a queue collects bytes; terminator publishes it, errors/too-long drop it
  function automatic void model(bit v, logic [7:0] d, bit e, bit a);
    int n_e;
    if (v && e) m_err = m_err == 255 ? 255 : m_err + 1;
    if (m_held) begin
      if (v && !e && d != T) m_ovf = 1;
      if (a) begin m_held = 0; m_match = 0; end
    end else if (m_drop) begin
      if (v && !e && d == T) m_drop = 0;
    end else if (v && e) begin
      if (q.size() > 0) begin m_drop = 1; q.delete(); end
    end else if (v && d == T) begin
      n_e = 0;
      foreach (q[i]) if (q[i] == E) n_e++;
      m_held = 1;
      m_len = q.size();
      m_match = q.size() == MC && n_e == MC;
      q.delete();
    end else if (v) begin
      if (q.size() == MAX_LEN) begin m_drop = 1; m_ovf = 1; q.delete(); end
      else begin
        if (q.size() == 0) m_ovf = 0;
        m_mem[q.size()] = d;
        q.push_back(d);
      end
    end
  endfunction
  task automatic compare();
    check("msg_valid", msg_valid, m_held);
    check("msg_len", msg_len, m_len);
    check("msg_match", msg_match, m_match);
    check("overflow", overflow, m_ovf);
    check("err_count", err_count, m_err);
    if (m_held && m_len > 0) begin
      rd_addr = 3'($urandom_range(m_len - 1, 0));
      #1 check("rd_data", rd_data, m_mem[rd_addr]);
    end
  endtask
  task automatic step(input bit v, input logic [7:0] d, input bit e = 0, input bit a = 0);
    rx_valid = v; rx_data = d; rx_err = e; msg_ack = a;
    @(posedge clk);
    model(v, d, e, a);
    #1;
    rx_valid = 0; rx_err = 0; msg_ack = 0;
    compare();
  endtask
  task automatic do_reset();
    rstn = 0;
    #2;
    q.delete();
    m_held = 0; m_drop = 0; m_match = 0; m_ovf = 0; m_len = 0; m_err = 0;
    compare();
    #2 rstn = 1;
  endtask
  initial begin
    #1000000 $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    #2 do_reset();
    step(1, E); step(1, E); step(1, E); step(1, T);
    check("tp1_valid", msg_valid, 1); check("tp1_len", msg_len, 3); check("tp1_match", msg_match, 1);
    for (int i = 0; i < 3; i++) begin
      rd_addr = 3'(i);
      #1 check("tp1_rd", rd_data, E);
    end
    step(0, 0, 0, 1);
    check("tp1_ack", msg_valid, 0);
    step(1, E); step(1, 8'h58); step(1, E); step(1, T);
    check("tp2_len", msg_len, 3); check("tp2_match", msg_match, 0);
    step(0, 0, 0, 1);
    step(1, E); step(1, E); step(1, T);
    check("tp2b_len", msg_len, 2); check("tp2b_match", msg_match, 0);
    step(0, 0, 0, 1);
    repeat (9) step(1, 8'h41);
    step(1, T);
    check("tp3_valid", msg_valid, 0); check("tp3_ovf", overflow, 1);
    step(1, E); step(1, E); step(1, E); step(1, T);
    check("tp3b_valid", msg_valid, 1); check("tp3b_ovf", overflow, 0);
    step(1, 8'h5A); step(1, T); step(0, 0);
    check("tp4_ovf", overflow, 1);
    for (int i = 0; i < 3; i++) begin
      rd_addr = 3'(i);
      #1 check("tp4_rd", rd_data, E);
    end
    step(0, 0, 0, 1);
    check("tp4_ack", msg_valid, 0);
    step(1, E); step(1, 8'hFF, 1); step(1, E); step(1, T);
    check("tp5_err", err_count, 1); check("tp5_valid", msg_valid, 0);
    repeat (300) step(1, 8'h00, 1);
    check("tp5_sat", err_count, 255);
    step(1, E); step(1, E);
    do_reset();
    step(1, E); step(1, E); step(1, E); step(1, T);
    check("tp6_len", msg_len, 3); check("tp6_match", msg_match, 1);
    step(0, 0, 0, 1);
    for (int n = 0; n < 4000; n++) begin
      int r;
      logic [7:0] d;
      r = $urandom_range(0, 9);
      d = r < 6 ? E : r < 8 ? T : r == 8 ? 8'h58 : 8'($urandom);
      if ($urandom_range(0, 499) == 0) do_reset();
      step($urandom_range(0, 3) != 0, d, $urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
